cpu_control_fsm: RTL
====================

CPU_CONTROL_FSM -- requirements
Module: cpu_control_fsm

Interface
REQ-001 Parameter MULDIV_CYCLES, default 32: number of cycles the MULDIV state is held; legal range 2..64.
REQ-002 Parameter HALT_ADDR, default 32'h0000_0000: next-PC value that halts the core.
REQ-003 Ports (name, direction, width, meaning):
- clk  in  1  single clock; all state changes on the rising edge
- reset  in  1  synchronous, active-high
- waitrequest_i  in  1  memory not ready; the current access is held
- opcode_i  in  6  opcode_t from IR
- function_i  in  6  func_t from IR
- regimm_i  in  5  regimm_t from IR
- b_cond_met_i  in  1  branch/link condition true
- addr_lo_i  in  2  low bits of the effective data address
- pc_next_i  in  32  next PC value
- state_o  out  3  current state_t
- active_o  out  1  high until HALT is reached
- pc_write_en_o, ir_write_en_o, ram_write_en_o, ram_read_en_o  out  1 each
- ram_byte_en_o  out  4  byte lanes; lane i is byte offset i
- ram_addr_sel_o, src_b_sel_o, regfile_write_en_o  out  1 each
- regfile_addr_3_sel_o  out  regfile_addr_sel_t  write-address source (RT/RD/RA)
- muldiv_start_o, hilo_write_en_o  out  1 each

Function
REQ-004 States: FETCH, EXEC1, EXEC2, MULDIV, HALT.
REQ-005 FETCH: ram_read_en_o=1, byte_en=4'b1111; advance to EXEC1 only when waitrequest_i=0, otherwise hold.
REQ-006 EXEC1: ir_write_en_o=1 on the cycle FETCH data is accepted. Loads drive read, addr_sel=1, src_b_sel=1; advance when waitrequest_i=0.
REQ-007 EXEC2: pc_write_en_o=1. Stores drive write, addr_sel=1, src_b_sel=1, and hold EXEC2 with pc_write_en_o=0 while waitrequest_i=1.
REQ-008 Byte enables: word 4'b1111; half {addr_lo_i[1]?4'b1100:4'b0011}; byte 4'b0001<<addr_lo_i. addr_lo_i[0] is ignored for halves.
REQ-009 Register write in EXEC2: ALU immediates and loads write RT. SPECIAL ALU/shift/MFHI/MFLO write RD. JALR writes RD gated by b_cond_met_i. JAL, BGEZAL and BLTZAL write RA gated by b_cond_met_i.
REQ-010 EXEC2 exit priority: pc_next_i==HALT_ADDR goes to HALT; MULT/MULTU/DIV/DIVU go to MULDIV; otherwise go to FETCH.
REQ-011 MULDIV: muldiv_start_o=1 for the first cycle only. The 6-bit down-counter is loaded with MULDIV_CYCLES-1. hilo_write_en_o=1 on the cycle the counter reads 0, then FETCH.
REQ-012 HALT: absorbing state; active_o=0 and every enable is 0.
REQ-013 Undefined opcodes and functions execute as NOPs (PC still advances); there is no trap.
REQ-014 All outputs are combinational from the state, the counter and the inputs; only state and counter are registered.

Reset
REQ-015 On reset the state is FETCH, the counter is 0 and active_o=1.
REQ-016 Reset mid-stall or mid-MULDIV abandons the operation; no hilo_write_en_o pulse follows.
REQ-017 During reset all outputs are forced 0 except active_o=1.

Configuration
REQ-018 Macro CPU_CONTROL_MULDIV_STALL_EN:
- Defined: REQ-011 applies.
- Undefined: the MULDIV state and counter are absent; MULT/DIV go to FETCH with hilo_write_en_o=1 in EXEC2 and muldiv_start_o tied 0.

Structure
REQ-019 Package codes holds state_t (including MULDIV and HALT), opcode_t, func_t, regimm_t and regfile_addr_sel_t (with RA added).
REQ-020 Sub-module cpu_control_byte_en: combinational lane decode per REQ-008, instantiated once.

Verification
REQ-021 ADDIU, waitrequest_i=0 -> FETCH, EXEC1, EXEC2, FETCH in 3 cycles; regfile_write_en_o=1 with RT selected in EXEC2.
REQ-022 LW with waitrequest_i=1 for 3 cycles in FETCH -> 3 extra FETCH cycles, ir_write_en_o pulses once.
REQ-023 SB with addr_lo_i=2'b10 -> byte_en=4'b0100; SH with addr_lo_i=2'b11 -> byte_en=4'b1100.
REQ-024 DIV with MULDIV_CYCLES=4, macro on -> 4 MULDIV cycles, muldiv_start_o on the first, hilo_write_en_o on the last.
REQ-025 JR with pc_next_i=0 -> HALT next cycle, active_o=0; reset asserted in HALT -> FETCH, active_o=1.
REQ-026 BLTZAL with b_cond_met_i=0 -> regfile_write_en_o=0 in EXEC2; with b_cond_met_i=1 -> 1 with RA selected.

Source files
------------

// File: rtl/cpu_control_fsm_pkg.sv
// Shared encodings for the multicycle CPU controller: FSM states, IR field
// codes, register-file write-address sources and memory access sizes.
package cpu_control_fsm_pkg;

    typedef logic [2:0] state_t;

    localparam state_t S_FETCH  = 3'd0;
    localparam state_t S_EXEC1  = 3'd1;
    localparam state_t S_EXEC2  = 3'd2;
    localparam state_t S_MULDIV = 3'd3;
    localparam state_t S_HALT   = 3'd4;

    typedef enum logic [5:0] {
        OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_J     = 6'h02, OP_JAL   = 6'h03,
        OP_BEQ     = 6'h04, OP_BNE    = 6'h05, OP_BLEZ  = 6'h06, OP_BGTZ  = 6'h07,
        OP_ADDI    = 6'h08, OP_ADDIU  = 6'h09, OP_SLTI  = 6'h0A, OP_SLTIU = 6'h0B,
        OP_ANDI    = 6'h0C, OP_ORI    = 6'h0D, OP_XORI  = 6'h0E, OP_LUI   = 6'h0F,
        OP_LB      = 6'h20, OP_LH     = 6'h21, OP_LW    = 6'h23, OP_LBU   = 6'h24,
        OP_LHU     = 6'h25, OP_SB     = 6'h28, OP_SH    = 6'h29, OP_SW    = 6'h2B
    } opcode_t;

    typedef enum logic [5:0] {
        FN_SLL  = 6'h00, FN_SRL   = 6'h02, FN_SRA  = 6'h03, FN_SLLV  = 6'h04,
        FN_SRLV = 6'h06, FN_SRAV  = 6'h07, FN_JR   = 6'h08, FN_JALR  = 6'h09,
        FN_MFHI = 6'h10, FN_MTHI  = 6'h11, FN_MFLO = 6'h12, FN_MTLO  = 6'h13,
        FN_MULT = 6'h18, FN_MULTU = 6'h19, FN_DIV  = 6'h1A, FN_DIVU  = 6'h1B,
        FN_ADD  = 6'h20, FN_ADDU  = 6'h21, FN_SUB  = 6'h22, FN_SUBU  = 6'h23,
        FN_AND  = 6'h24, FN_OR    = 6'h25, FN_XOR  = 6'h26, FN_NOR   = 6'h27,
        FN_SLT  = 6'h2A, FN_SLTU  = 6'h2B
    } func_t;

    typedef enum logic [4:0] {
        RI_BLTZ = 5'h00, RI_BGEZ = 5'h01, RI_BLTZAL = 5'h10, RI_BGEZAL = 5'h11
    } regimm_t;

    typedef enum logic [1:0] {
        RF_SEL_RT = 2'd0,
        RF_SEL_RD = 2'd1,
        RF_SEL_RA = 2'd2
    } regfile_addr_sel_t;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } mem_size_t;

endpackage

// File: rtl/cpu_control_fsm_byte_en.sv
// Byte-lane decode for data accesses; lane i is byte offset i. Halfword
// accesses ignore addr_lo_i[0].
module cpu_control_byte_en
    import cpu_control_fsm_pkg::*;
(
    input  mem_size_t  size_i,
    input  logic [1:0] addr_lo_i,
    output logic [3:0] byte_en_o
);

    // Select the lanes touched by the access size and low address bits
    always_comb begin
        byte_en_o = 4'b1111;
        case (size_i)
            SIZE_BYTE: byte_en_o = 4'b0001 << addr_lo_i;
            SIZE_HALF: byte_en_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
            default:   byte_en_o = 4'b1111;
        endcase
    end

endmodule

// File: rtl/cpu_control_fsm.sv
// Multicycle CPU control FSM: FETCH -> EXEC1 -> EXEC2 -> FETCH, with an
// optional multiply/divide stall state and an absorbing HALT.
// Build option CPU_CONTROL_MULDIV_STALL_EN: when defined, MULT/DIV spend
// MULDIV_CYCLES in the MULDIV state; otherwise HI/LO are written in EXEC2.
//
// state  | meaning
// FETCH  | instruction read; IR captured when memory accepts
// EXEC1  | loads issue their data read
// EXEC2  | PC update, stores, register write-back, exit decision
// MULDIV | multiply/divide in progress, counter runs down to 0
// HALT   | core stopped until reset
module cpu_control_fsm
    import cpu_control_fsm_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 32,
    parameter logic [31:0] HALT_ADDR     = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              waitrequest_i,
    input  logic [5:0]        opcode_i,
    input  logic [5:0]        function_i,
    input  logic [4:0]        regimm_i,
    input  logic              b_cond_met_i,
    input  logic [1:0]        addr_lo_i,
    input  logic [31:0]       pc_next_i,
    output logic [2:0]        state_o,
    output logic              active_o,
    output logic              pc_write_en_o,
    output logic              ir_write_en_o,
    output logic              ram_write_en_o,
    output logic              ram_read_en_o,
    output logic [3:0]        ram_byte_en_o,
    output logic              ram_addr_sel_o,
    output logic              src_b_sel_o,
    output logic              regfile_write_en_o,
    output regfile_addr_sel_t regfile_addr_3_sel_o,
    output logic              muldiv_start_o,
    output logic              hilo_write_en_o
);

    state_t            state_q, state_d;
    logic              is_load, is_store, is_muldiv, rf_we_dec;
    regfile_addr_sel_t rf_sel_dec;
    mem_size_t         mem_size;
    logic [3:0]        lane_be;

`ifdef CPU_CONTROL_MULDIV_STALL_EN
    localparam logic [5:0] CNT_LOAD = 6'(MULDIV_CYCLES - 1);
    logic [5:0] cnt_q, cnt_d;
`else
    logic [31:0] unused_muldiv_cycles;
    assign unused_muldiv_cycles = MULDIV_CYCLES;
`endif

    cpu_control_byte_en u_byte_en (
        .size_i    (mem_size),
        .addr_lo_i (addr_lo_i),
        .byte_en_o (lane_be)
    );

    // Instruction class decode; unknown encodings fall through as NOPs
    always_comb begin
        is_load    = 1'b0;
        is_store   = 1'b0;
        is_muldiv  = 1'b0;
        rf_we_dec  = 1'b0;
        rf_sel_dec = RF_SEL_RT;
        mem_size   = SIZE_WORD;
        case (opcode_i)
            OP_SPECIAL: begin
                rf_sel_dec = RF_SEL_RD;
                case (function_i)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV,
                    FN_MFHI, FN_MFLO, FN_ADD, FN_ADDU, FN_SUB, FN_SUBU,
                    FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        rf_we_dec = 1'b1;
                    FN_JALR:
                        rf_we_dec = b_cond_met_i;
                    FN_MULT, FN_MULTU, FN_DIV, FN_DIVU:
                        is_muldiv = 1'b1;
                    default: ;
                endcase
            end
            OP_REGIMM: begin
                if (regimm_i == RI_BLTZAL || regimm_i == RI_BGEZAL) begin
                    rf_we_dec  = b_cond_met_i;
                    rf_sel_dec = RF_SEL_RA;
                end
            end
            OP_JAL: begin
                rf_we_dec  = b_cond_met_i;
                rf_sel_dec = RF_SEL_RA;
            end
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                rf_we_dec = 1'b1;
            OP_LB, OP_LBU: begin
                is_load = 1'b1; rf_we_dec = 1'b1; mem_size = SIZE_BYTE;
            end
            OP_LH, OP_LHU: begin
                is_load = 1'b1; rf_we_dec = 1'b1; mem_size = SIZE_HALF;
            end
            OP_LW: begin
                is_load = 1'b1; rf_we_dec = 1'b1;
            end
            OP_SB: begin
                is_store = 1'b1; mem_size = SIZE_BYTE;
            end
            OP_SH: begin
                is_store = 1'b1; mem_size = SIZE_HALF;
            end
            OP_SW:
                is_store = 1'b1;
            default: ;
        endcase
    end

    // Next state, counter and all control outputs; reset overrides the outputs
    always_comb begin
        state_d              = state_q;
`ifdef CPU_CONTROL_MULDIV_STALL_EN
        cnt_d                = cnt_q;
`endif
        state_o              = state_q;
        active_o             = 1'b1;
        pc_write_en_o        = 1'b0;
        ir_write_en_o        = 1'b0;
        ram_write_en_o       = 1'b0;
        ram_read_en_o        = 1'b0;
        ram_byte_en_o        = 4'b0000;
        ram_addr_sel_o       = 1'b0;
        src_b_sel_o          = 1'b0;
        regfile_write_en_o   = 1'b0;
        regfile_addr_3_sel_o = RF_SEL_RT;
        muldiv_start_o       = 1'b0;
        hilo_write_en_o      = 1'b0;
        case (state_q)
            S_FETCH: begin
                ram_read_en_o = 1'b1;
                ram_byte_en_o = 4'b1111;
                if (!waitrequest_i) begin
                    ir_write_en_o = 1'b1;
                    state_d       = S_EXEC1;
                end
            end
            S_EXEC1: begin
                if (is_load) begin
                    ram_read_en_o  = 1'b1;
                    ram_byte_en_o  = lane_be;
                    ram_addr_sel_o = 1'b1;
                    src_b_sel_o    = 1'b1;
                    if (!waitrequest_i) state_d = S_EXEC2;
                end else begin
                    state_d = S_EXEC2;
                end
            end
            S_EXEC2: begin
                regfile_addr_3_sel_o = rf_sel_dec;
                if (is_store) begin
                    ram_write_en_o = 1'b1;
                    ram_byte_en_o  = lane_be;
                    ram_addr_sel_o = 1'b1;
                    src_b_sel_o    = 1'b1;
                end
                // A stalled store holds EXEC2 without committing anything
                if (!(is_store && waitrequest_i)) begin
                    pc_write_en_o      = 1'b1;
                    regfile_write_en_o = rf_we_dec;
`ifndef CPU_CONTROL_MULDIV_STALL_EN
                    hilo_write_en_o    = is_muldiv;
`endif
                    if (pc_next_i == HALT_ADDR) begin
                        state_d = S_HALT;
`ifdef CPU_CONTROL_MULDIV_STALL_EN
                    end else if (is_muldiv) begin
                        state_d = S_MULDIV;
                        cnt_d   = CNT_LOAD;
`endif
                    end else begin
                        state_d = S_FETCH;
                    end
                end
            end
`ifdef CPU_CONTROL_MULDIV_STALL_EN
            S_MULDIV: begin
                muldiv_start_o = (cnt_q == CNT_LOAD);
                if (cnt_q == 6'd0) begin
                    hilo_write_en_o = 1'b1;
                    state_d         = S_FETCH;
                end else begin
                    cnt_d = cnt_q - 6'd1;
                end
            end
`endif
            S_HALT: begin
                active_o = 1'b0;
            end
            default: state_d = S_FETCH;
        endcase
        if (reset) begin
            state_o              = 3'd0;
            active_o             = 1'b1;
            pc_write_en_o        = 1'b0;
            ir_write_en_o        = 1'b0;
            ram_write_en_o       = 1'b0;
            ram_read_en_o        = 1'b0;
            ram_byte_en_o        = 4'b0000;
            ram_addr_sel_o       = 1'b0;
            src_b_sel_o          = 1'b0;
            regfile_write_en_o   = 1'b0;
            regfile_addr_3_sel_o = RF_SEL_RT;
            muldiv_start_o       = 1'b0;
            hilo_write_en_o      = 1'b0;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

`ifdef CPU_CONTROL_MULDIV_STALL_EN
    // Multiply/divide down-counter
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= 6'd0;
        else       cnt_q <= cnt_d;
    end
`endif

endmodule
